// File: rtl/aes_chip_driver.sv
// aes_chip_driver
// Sequences one AES-128 chip test run once the chip reset is released:
// settle, stream key then plaintext bytewise (MSB byte first), strobe start,
// wait for done with a timeout, read back 16 ciphertext bytes, compare against
// the expected value and report. A run pulse in DONE repeats the run without
// settling.
//
// Ports
//   clk, rst_n           clock, asynchronous active-low reset
//   chip_rst_n           chip reset from the reset generator (sync to clk);
//                        low aborts the run back to IDLE
//   run                  1-cycle restart pulse, honoured only in DONE
//   key, pt, exp_ct      key, plaintext, expected ciphertext (128 bit)
//   chip_din/_vld/_sel   byte stream to the chip (sel 0 = key, 1 = plaintext)
//   chip_start           1-cycle start strobe
//   chip_done            chip finished (level or pulse)
//   chip_dout_rd         read strobe; chip_dout carries the byte one cycle later
//   chip_dout            ciphertext byte from the chip
//   busy                 high in every state except IDLE and DONE
//   test_done            high in DONE
//   test_pass            ciphertext matched exp_ct (valid with test_done)
//   timeout_err          chip never signalled done (valid with test_done)
//   ct_out               captured ciphertext, MSB byte first
//   latency              cycles from chip_start to chip_done, saturating
module aes_chip_driver #(
    parameter int unsigned SETTLE_CYC  = 4,
    parameter int unsigned TIMEOUT_CYC = 1024,
    parameter int unsigned NBYTES      = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         chip_rst_n,
    input  logic         run,
    input  logic [127:0] key,
    input  logic [127:0] pt,
    input  logic [127:0] exp_ct,
    output logic [7:0]   chip_din,
    output logic         chip_din_vld,
    output logic         chip_din_sel,
    output logic         chip_start,
    input  logic         chip_done,
    output logic         chip_dout_rd,
    input  logic [7:0]   chip_dout,
    output logic         busy,
    output logic         test_done,
    output logic         test_pass,
    output logic         timeout_err,
    output logic [127:0] ct_out,
    output logic [15:0]  latency
);

    // One shared counter covers settle, byte index, read index and timeout.
    localparam int unsigned CW = $clog2(TIMEOUT_CYC + SETTLE_CYC + NBYTES + 1);

    localparam logic [CW-1:0] SETTLE_LAST = CW'(SETTLE_CYC - 1);
    localparam logic [CW-1:0] BYTE_LAST   = CW'(NBYTES - 1);
    localparam logic [CW-1:0] READ_LAST   = CW'(NBYTES);
    localparam logic [CW-1:0] TO_LAST     = CW'(TIMEOUT_CYC - 1);

    typedef enum logic [3:0] {
        StIdle,
        StSettle,
        StLoadKey,
        StLoadPt,
        StStart,
        StWaitDone,
        StRead,
        StCheck,
        StDone
    } state_e;

    state_e        state;
    logic [CW-1:0] cnt;

    // Byte idx of a 128-bit operand, counted from the MSB end.
    function automatic logic [7:0] byte_at(input logic [127:0] v, input logic [CW-1:0] idx);
        logic [127:0] sh;
        sh = v << {idx, 3'b000};
        return sh[127:120];
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= StIdle;
            cnt          <= '0;
            chip_din     <= '0;
            chip_din_vld <= 1'b0;
            chip_din_sel <= 1'b0;
            chip_start   <= 1'b0;
            chip_dout_rd <= 1'b0;
            busy         <= 1'b0;
            test_done    <= 1'b0;
            test_pass    <= 1'b0;
            timeout_err  <= 1'b0;
            ct_out       <= '0;
            latency      <= '0;
        end else if (!chip_rst_n) begin
            // Chip held in reset: abandon the run but keep the last ciphertext.
            state        <= StIdle;
            cnt          <= '0;
            chip_din     <= '0;
            chip_din_vld <= 1'b0;
            chip_din_sel <= 1'b0;
            chip_start   <= 1'b0;
            chip_dout_rd <= 1'b0;
            busy         <= 1'b0;
            test_done    <= 1'b0;
            test_pass    <= 1'b0;
            timeout_err  <= 1'b0;
            latency      <= '0;
        end else begin
            chip_start <= 1'b0;
            case (state)
                StIdle: begin
                    state <= StSettle;
                    cnt   <= '0;
                    busy  <= 1'b1;
                end

                StSettle: begin
                    if (cnt == SETTLE_LAST) begin
                        state        <= StLoadKey;
                        cnt          <= '0;
                        chip_din     <= byte_at(key, '0);
                        chip_din_vld <= 1'b1;
                        chip_din_sel <= 1'b0;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end

                StLoadKey: begin
                    if (cnt == BYTE_LAST) begin
                        state        <= StLoadPt;
                        cnt          <= '0;
                        chip_din     <= byte_at(pt, '0);
                        chip_din_sel <= 1'b1;
                    end else begin
                        cnt      <= cnt + 1'b1;
                        chip_din <= byte_at(key, cnt + 1'b1);
                    end
                end

                StLoadPt: begin
                    if (cnt == BYTE_LAST) begin
                        state        <= StStart;
                        cnt          <= '0;
                        chip_din     <= '0;
                        chip_din_vld <= 1'b0;
                        chip_din_sel <= 1'b0;
                        chip_start   <= 1'b1;
                        latency      <= '0;
                    end else begin
                        cnt      <= cnt + 1'b1;
                        chip_din <= byte_at(pt, cnt + 1'b1);
                    end
                end

                StStart: begin
                    state <= StWaitDone;
                    cnt   <= '0;
                end

                StWaitDone: begin
                    // Counting includes the cycle in which done is sampled.
                    if (latency != 16'hFFFF) begin
                        latency <= latency + 16'd1;
                    end
                    if (chip_done) begin
                        state        <= StRead;
                        cnt          <= '0;
                        chip_dout_rd <= 1'b1;
                    end else if (cnt == TO_LAST) begin
                        state       <= StDone;
                        cnt         <= '0;
                        busy        <= 1'b0;
                        test_done   <= 1'b1;
                        test_pass   <= 1'b0;
                        timeout_err <= 1'b1;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end

                StRead: begin
                    // Strobe k goes out while cnt == k; its byte arrives while cnt == k+1.
                    for (int b = 0; b < int'(NBYTES); b++) begin
                        if (cnt == CW'(b + 1)) begin
                            ct_out[127-8*b -: 8] <= chip_dout;
                        end
                    end
                    if (cnt == BYTE_LAST) begin
                        chip_dout_rd <= 1'b0;
                    end
                    if (cnt == READ_LAST) begin
                        state <= StCheck;
                        cnt   <= '0;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end

                StCheck: begin
                    state     <= StDone;
                    busy      <= 1'b0;
                    test_done <= 1'b1;
                    test_pass <= (ct_out == exp_ct);
                end

                StDone: begin
                    if (run) begin
                        state        <= StLoadKey;
                        cnt          <= '0;
                        busy         <= 1'b1;
                        test_done    <= 1'b0;
                        test_pass    <= 1'b0;
                        timeout_err  <= 1'b0;
                        latency      <= '0;
                        chip_din     <= byte_at(key, '0);
                        chip_din_vld <= 1'b1;
                        chip_din_sel <= 1'b0;
                    end
                end

                default: begin
                    state <= StIdle;
                    cnt   <= '0;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_aes_chip_driver.sv
// Bench for aes_chip_driver: byte stream and run results are checked through
// scoreboard queues filled when each run is set up; a simple chip model answers
// start with done after a fixed delay and returns a programmed ciphertext.
module tb_aes_chip_driver;

    localparam int unsigned SETTLE_CYC  = 4;
    localparam int unsigned TIMEOUT_CYC = 1024;
    localparam int unsigned DONE_DLY    = 11;

    localparam logic [127:0] KEY1 = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] PT1  = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] CT1  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] KEY2 = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] PT2  = 128'h3243f6a8885a308d313198a2e0370734;
    localparam logic [127:0] CT2  = 128'h3925841d02dc09fbdc118597196a0b32;

    logic         clk;
    logic         rst_n;
    logic         chip_rst_n;
    logic         run;
    logic [127:0] key;
    logic [127:0] pt;
    logic [127:0] exp_ct;
    logic [7:0]   chip_din;
    logic         chip_din_vld;
    logic         chip_din_sel;
    logic         chip_start;
    logic         chip_done = 1'b0;
    logic         chip_dout_rd;
    logic [7:0]   chip_dout = 8'h00;
    logic         busy;
    logic         test_done;
    logic         test_pass;
    logic         timeout_err;
    logic [127:0] ct_out;
    logic [15:0]  latency;

    aes_chip_driver #(
        .SETTLE_CYC (SETTLE_CYC),
        .TIMEOUT_CYC(TIMEOUT_CYC),
        .NBYTES     (16)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .chip_rst_n  (chip_rst_n),
        .run         (run),
        .key         (key),
        .pt          (pt),
        .exp_ct      (exp_ct),
        .chip_din    (chip_din),
        .chip_din_vld(chip_din_vld),
        .chip_din_sel(chip_din_sel),
        .chip_start  (chip_start),
        .chip_done   (chip_done),
        .chip_dout_rd(chip_dout_rd),
        .chip_dout   (chip_dout),
        .busy        (busy),
        .test_done   (test_done),
        .test_pass   (test_pass),
        .timeout_err (timeout_err),
        .ct_out      (ct_out),
        .latency     (latency)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int unsigned n_cmp = 0;
    int unsigned n_err = 0;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    typedef struct packed {
        logic         pass;
        logic         tmo;
        logic [15:0]  lat;
        logic [127:0] ct;
    } res_t;

    logic [8:0] din_q[$];
    res_t       res_q[$];

    // Chip model
    logic         done_en = 1'b1;
    logic [127:0] chip_ct = CT1;
    int           dcnt    = -1;
    int           ridx    = 0;
    int           rd_cnt  = 0;
    int           cyc     = 0;

    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk) begin
        chip_done <= 1'b0;
        if (chip_start) begin
            ridx <= 0;
            if (done_en) dcnt <= int'(DONE_DLY) - 2;
        end else if (dcnt == 0) begin
            chip_done <= 1'b1;
            dcnt      <= -1;
        end else if (dcnt > 0) begin
            dcnt <= dcnt - 1;
        end
        if (chip_dout_rd) begin
            chip_dout <= chip_ct[127-8*ridx -: 8];
            ridx      <= ridx + 1;
            rd_cnt    <= rd_cnt + 1;
        end
    end

    // Byte stream monitor
    always @(negedge clk) begin
        if (rst_n && chip_din_vld) begin
            if (din_q.size() == 0) begin
                check("din_q_size", 128'(din_q.size()), 128'd1);
            end else begin
                logic [8:0] e;
                e = din_q.pop_front();
                check("din", 128'({chip_din_sel, chip_din}), 128'(e));
            end
        end
    end

    task automatic push_load(input logic [127:0] k, input logic [127:0] p, input int npt);
        for (int i = 0; i < 16; i++) din_q.push_back({1'b0, k[127-8*i -: 8]});
        for (int i = 0; i < npt; i++) din_q.push_back({1'b1, p[127-8*i -: 8]});
    endtask

    task automatic wait_done(input int budget);
        int n;
        n = 0;
        while (!test_done && n < budget) begin
            @(negedge clk);
            n++;
        end
        if (!test_done) check("test_done", 128'(test_done), 128'd1);
    endtask

    task automatic wait_start(input int budget);
        int n;
        n = 0;
        while (!chip_start && n < budget) begin
            @(negedge clk);
            n++;
        end
        if (!chip_start) check("chip_start", 128'(chip_start), 128'd1);
    endtask

    task automatic check_result();
        res_t e;
        e = res_q.pop_front();
        check("test_pass", 128'(test_pass), 128'(e.pass));
        check("timeout_err", 128'(timeout_err), 128'(e.tmo));
        check("latency", 128'(latency), 128'(e.lat));
        check("ct_out", ct_out, e.ct);
        check("din_left", 128'(din_q.size()), 128'd0);
    endtask

    task automatic settle_check();
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!chip_din_vld && n < 50);
        check("settle", 128'(n), 128'(SETTLE_CYC + 1));
    endtask

    // Pulse run in DONE; the next cycle must already be LOAD_KEY with flags cleared.
    task automatic pulse_run();
        @(negedge clk);
        run = 1'b1;
        @(negedge clk);
        run = 1'b0;
        check("run_restart",
              128'({busy, test_done, test_pass, timeout_err, chip_din_vld, chip_din_sel, latency}),
              128'({1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 16'h0000}));
    endtask

    initial begin
        int c0;
        int r0;
        int npt;
        rst_n      = 1'b0;
        chip_rst_n = 1'b0;
        run        = 1'b0;
        key        = '0;
        pt         = '0;
        exp_ct     = '0;
        repeat (3) @(negedge clk);
        check("reset_outs",
              128'({chip_din, chip_din_vld, chip_din_sel, chip_start, chip_dout_rd, busy,
                    test_done, test_pass, timeout_err, latency}), 128'd0);
        check("reset_ct", ct_out, 128'd0);
        rst_n = 1'b1;
        @(negedge clk);
        check("idle_hold", 128'({busy, chip_din_vld}), 128'd0);

        // Run 1: FIPS-197 vector, passes.
        key = KEY1; pt = PT1; exp_ct = CT1;
        push_load(KEY1, PT1, 16);
        res_q.push_back('{pass: 1'b1, tmo: 1'b0, lat: 16'(DONE_DLY), ct: CT1});
        chip_rst_n = 1'b1;
        settle_check();
        wait_done(300);
        check_result();

        // Run 2: wrong expected value; a run pulse during WAIT_DONE is ignored.
        exp_ct = CT1 ^ 128'd1;
        push_load(KEY1, PT1, 16);
        res_q.push_back('{pass: 1'b0, tmo: 1'b0, lat: 16'(DONE_DLY), ct: CT1});
        pulse_run();
        wait_start(100);
        @(negedge clk);
        run = 1'b1;
        @(negedge clk);
        run = 1'b0;
        check("run_in_wait", 128'({busy, chip_din_vld}), 128'({1'b1, 1'b0}));
        wait_done(300);
        check_result();

        // Run 3: chip never finishes.
        done_en = 1'b0;
        exp_ct  = CT1;
        push_load(KEY1, PT1, 16);
        res_q.push_back('{pass: 1'b0, tmo: 1'b1, lat: 16'(TIMEOUT_CYC), ct: CT1});
        r0 = rd_cnt;
        pulse_run();
        wait_start(100);
        c0 = cyc;
        wait_done(TIMEOUT_CYC + 50);
        check("timeout_cycles", 128'(cyc - c0), 128'(TIMEOUT_CYC + 1));
        check("timeout_no_rd", 128'(rd_cnt - r0), 128'd0);
        check_result();

        // Run 4: new key/plaintext (FIPS-197 appendix B), passes.
        done_en = 1'b1;
        key = KEY2; pt = PT2; exp_ct = CT2; chip_ct = CT2;
        push_load(KEY2, PT2, 16);
        res_q.push_back('{pass: 1'b1, tmo: 1'b0, lat: 16'(DONE_DLY), ct: CT2});
        pulse_run();
        wait_done(300);
        check_result();

        // Run 5: chip reset pulled while plaintext byte 7 is on the bus.
        push_load(KEY2, PT2, 8);
        pulse_run();
        npt = 0;
        for (int i = 0; i < 60 && npt < 8; i++) begin
            @(negedge clk);
            if (chip_din_vld && chip_din_sel) npt++;
        end
        check("abort_reach_pt7", 128'(npt), 128'd8);
        chip_rst_n = 1'b0;
        @(negedge clk);
        check("abort_outs", 128'({chip_din_vld, busy, test_done, chip_start}), 128'd0);
        check("abort_ct_kept", ct_out, CT2);
        check("abort_din_left", 128'(din_q.size()), 128'd0);
        push_load(KEY2, PT2, 16);
        res_q.push_back('{pass: 1'b1, tmo: 1'b0, lat: 16'(DONE_DLY), ct: CT2});
        chip_rst_n = 1'b1;
        settle_check();
        wait_done(300);
        check_result();

        // Run 6: async reset in the middle of READ.
        push_load(KEY2, PT2, 16);
        pulse_run();
        for (int i = 0; i < 200 && !chip_dout_rd; i++) @(negedge clk);
        check("read_reached", 128'(chip_dout_rd), 128'd1);
        repeat (3) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("async_rst_outs",
              128'({chip_din, chip_din_vld, chip_din_sel, chip_start, chip_dout_rd, busy,
                    test_done, test_pass, timeout_err, latency}), 128'd0);
        check("async_rst_ct", ct_out, 128'd0);
        check("final_din_left", 128'(din_q.size()), 128'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
